// File: rtl/commit_trace_queue.sv
// Elastic trace buffer between the retirement port and the co-simulation checker.
// Overflowing records are dropped with sequence-numbered loss accounting; an idle watchdog flags hangs.
module commit_trace_queue #(
    parameter int DEPTH      = 16,
    parameter int XLEN       = 64,
    parameter int HARTID_W   = 8,
    parameter int SEQ_W      = 32,
    parameter int HANG_LIMIT = 100000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [HARTID_W-1:0]      in_hartid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_inst,
    input  logic [XLEN-1:0]          in_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [HARTID_W-1:0]      out_hartid,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic [XLEN-1:0]          out_wdata,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic [SEQ_W-1:0]         drop_count,
    output logic                     overflow,
    output logic                     hang
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int HW = $clog2(HANG_LIMIT + 1);

    typedef struct packed {
        logic [HARTID_W-1:0] hartid;
        logic [XLEN-1:0]     pc;
        logic [31:0]         inst;
        logic [XLEN-1:0]     wdata;
        logic [SEQ_W-1:0]    seq;
    } rec_t;

    rec_t mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] drop_q, drop_d;
    logic             overflow_q, overflow_d;
    logic             hang_q, hang_d;
    logic [HW-1:0]    idle_q, idle_d;

    logic pop, push, drop, full, not_empty;
    rec_t head;

    assign not_empty = (level_q != '0);
    assign full      = (level_q == LW'(DEPTH));
    assign pop       = not_empty && out_ready;
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d   = rd_ptr_q + (pop  ? AW'(1) : AW'(0));
        level_d    = level_q + LW'(push) - LW'(pop);
        seq_d      = in_valid ? seq_q + SEQ_W'(1) : seq_q;
        drop_d     = (drop && (drop_q != '1)) ? drop_q + SEQ_W'(1) : drop_q;
        overflow_d = overflow_q | drop;
        // Idle counter saturates at the limit so hang stays meaningful for arbitrarily long stalls.
        if (in_valid) begin
            idle_d = '0;
        end else if (idle_q != HW'(HANG_LIMIT)) begin
            idle_d = idle_q + HW'(1);
        end else begin
            idle_d = idle_q;
        end
        hang_d = hang_q | (idle_d == HW'(HANG_LIMIT));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            hang_q     <= 1'b0;
            idle_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            hang_q     <= hang_d;
            idle_q     <= idle_d;
        end
    end

    // Storage carries no reset; stale entries are hidden by gating the outputs with out_valid.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= '{hartid: in_hartid, pc: in_pc, inst: in_inst,
                                 wdata: in_wdata, seq: seq_q};
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = not_empty;
    assign out_hartid = not_empty ? head.hartid : '0;
    assign out_pc     = not_empty ? head.pc     : '0;
    assign out_inst   = not_empty ? head.inst   : '0;
    assign out_wdata  = not_empty ? head.wdata  : '0;
    assign out_seq    = not_empty ? head.seq    : '0;
    assign level      = level_q;
    assign drop_count = drop_q;
    assign overflow   = overflow_q;
    assign hang       = hang_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Bench for commit_trace_queue: directed phases plus random traffic against a queue-based model.
module tb_commit_trace_queue;
    localparam int DEPTH = 16;
    localparam int XLEN  = 64;
    localparam int HW    = 8;
    localparam int SEQ_W = 8;
    localparam int HL    = 8;
    localparam int SEQ_MOD  = 1 << SEQ_W;
    localparam int DROP_MAX = SEQ_MOD - 1;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic [HW-1:0]   in_hartid = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [31:0]     in_inst = '0;
    logic [XLEN-1:0] in_wdata = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [HW-1:0]   out_hartid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_wdata;
    logic [SEQ_W-1:0] out_seq;
    logic [4:0]      level;
    logic [SEQ_W-1:0] drop_count;
    logic            overflow;
    logic            hang;

    commit_trace_queue #(
        .DEPTH(DEPTH), .XLEN(XLEN), .HARTID_W(HW), .SEQ_W(SEQ_W), .HANG_LIMIT(HL)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_hartid(in_hartid), .in_pc(in_pc),
        .in_inst(in_inst), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hartid(out_hartid), .out_pc(out_pc), .out_inst(out_inst),
        .out_wdata(out_wdata), .out_seq(out_seq),
        .level(level), .drop_count(drop_count), .overflow(overflow), .hang(hang)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [HW-1:0]   hartid;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] wdata;
        int              seq;
    } rec_t;

    rec_t q[$];
    int   seq_next = 0;
    int   drops = 0;
    bit   ovf_m = 0;
    int   idle_run = 0;
    bit   hang_m = 0;
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one clock: update the model from the inputs in effect, then compare after the edge.
    task automatic tick();
        rec_t r;
        if (!reset) begin
            q.delete();
            seq_next = 0; drops = 0; ovf_m = 0; idle_run = 0; hang_m = 0;
        end else begin
            if (q.size() > 0 && out_ready) r = q.pop_front();
            if (in_valid) begin
                if (q.size() < DEPTH) begin
                    r = '{hartid: in_hartid, pc: in_pc, inst: in_inst, wdata: in_wdata, seq: seq_next};
                    q.push_back(r);
                end else begin
                    if (drops < DROP_MAX) drops++;
                    ovf_m = 1;
                end
                seq_next = (seq_next + 1) % SEQ_MOD;
                idle_run = 0;
            end else begin
                idle_run++;
            end
            if (idle_run >= HL) hang_m = 1;
        end
        @(posedge clock);
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("level", 64'(level), 64'(q.size()));
        if (q.size() > 0) begin
            chk("out_seq", 64'(out_seq), 64'(q[0].seq));
            chk("out_pc", out_pc, q[0].pc);
            chk("out_hartid", 64'(out_hartid), 64'(q[0].hartid));
            chk("out_inst", 64'(out_inst), 64'(q[0].inst));
            chk("out_wdata", out_wdata, q[0].wdata);
        end
        chk("drop_count", 64'(drop_count), 64'(drops));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        chk("hang", 64'(hang), 64'(hang_m));
    endtask

    task automatic rand_rec();
        in_hartid = HW'($urandom);
        in_pc     = {$urandom, $urandom};
        in_inst   = $urandom;
        in_wdata  = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        // Reset state, outputs all zero
        tick();
        tick();
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_seq", 64'(out_seq), 64'h0);
        chk("rst_out_wdata", out_wdata, 64'h0);
        reset = 1'b1;

        // Watchdog: hang on the 8th idle edge, sticky through later traffic
        for (int i = 0; i < HL - 1; i++) tick();
        chk("hang_before_limit", 64'(hang), 64'h0);
        tick();
        chk("hang_at_limit", 64'(hang), 64'h1);
        in_valid = 1'b1; out_ready = 1'b1; rand_rec();
        tick();
        in_valid = 1'b0;
        tick();
        chk("hang_sticky", 64'(hang), 64'h1);
        do_reset();
        chk("hang_cleared", 64'(hang), 64'h0);

        // Single record, one-cycle latency
        out_ready = 1'b1; in_valid = 1'b1;
        in_pc = 64'h8000_0000; in_inst = 32'h0000_0013; in_wdata = '0; in_hartid = '0;
        tick();
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_pc", out_pc, 64'h8000_0000);
        chk("single_seq", 64'(out_seq), 64'h0);
        in_valid = 1'b0;
        tick();
        chk("single_drained", 64'(out_valid), 64'h0);

        // Overfill with 20 records, then full + simultaneous pop, then drain
        do_reset();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; rand_rec();
            tick();
        end
        chk("fill_level", 64'(level), 64'd16);
        chk("fill_drops", 64'(drop_count), 64'd4);
        chk("fill_ovf", 64'(overflow), 64'h1);
        out_ready = 1'b1; rand_rec();
        tick();
        chk("full_pop_level", 64'(level), 64'd16);
        chk("full_pop_drops", 64'(drop_count), 64'd4);
        chk("full_pop_head_seq", 64'(out_seq), 64'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("drained", 64'(level), 64'd0);

        // Reset mid-operation with level 5 and 3 drops
        do_reset();
        for (int i = 0; i < 19; i++) begin
            in_valid = 1'b1; rand_rec();
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("pre_rst_level", 64'(level), 64'd5);
        chk("pre_rst_drops", 64'(drop_count), 64'd3);
        do_reset();
        chk("post_rst_level", 64'(level), 64'd0);
        chk("post_rst_drops", 64'(drop_count), 64'd0);
        chk("post_rst_ovf", 64'(overflow), 64'h0);
        in_valid = 1'b1; out_ready = 1'b0; rand_rec();
        tick();
        chk("post_rst_seq", 64'(out_seq), 64'd0);

        // Random traffic: alternating out_ready, then fully random handshake
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            rand_rec();
            out_ready = (i < 500) ? i[0] : ($urandom_range(0, 1) == 1);
            tick();
        end

        // Drop counter saturation
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < DEPTH + DROP_MAX + 5; i++) begin
            rand_rec();
            tick();
        end
        chk("drop_saturated", 64'(drop_count), 64'(DROP_MAX));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
